and2_tester: RTL and testbench

AND2_TESTER -- requirements
Module: and2_tester

---
 rtl/and2_tester_pkg.sv | 21 ++
 rtl/and2_tester_cnt.sv | 29 ++
 rtl/and2_tester.sv | 159 +++++++++++++++
 tb/tb_and2_tester.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/and2_tester_pkg.sv
// Shared types and constants for the 2-input AND cell tester.
// Holds the FSM state type and the expected-output table.
package and2_tester_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam int VEC_W = 2;

    // Bit v is the AND of the two bits of v.
    localparam logic [3:0] EXP_TBL = 4'b1000;

    function automatic logic exp_q(input logic [VEC_W-1:0] v);
        return EXP_TBL[v];
    endfunction

endpackage

// File: rtl/and2_tester_cnt.sv
// Loadable up-counter with a terminal-count flag.
// Used for both the settle counter and the loop counter.
module and2_tester_cnt #(
    parameter int             W    = 4,
    parameter logic [W-1:0]   TERM = '0
) (
    input  logic         i_ck,
    input  logic         i_nrst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_inc,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_ck or negedge i_nrst) begin
        if (!i_nrst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == TERM);

endmodule

// File: rtl/and2_tester.sv
// Exhaustive sweep tester for a 2-input AND cell.
// Define AND2_TESTER_ERRCNT_EN to add the err_cnt mismatch counter.
module and2_tester
    import and2_tester_pkg::*;
#(
    parameter int SETTLE = 2,
    parameter int LOOPS  = 1
) (
    input  logic       ck,
    input  logic       nrst,
    input  logic       start,
    input  logic       q,
    output logic       i0,
    output logic       i1,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_vec
`ifdef AND2_TESTER_ERRCNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    state_t             r_state;
    logic [VEC_W-1:0]   r_v;
    logic [3:0]         r_fail;
    logic               r_pass;
    logic               r_busy;
    logic               r_done;
    logic               r_i0;
    logic               r_i1;

    logic               w_set_tc;
    logic               w_loop_tc;
    logic               w_set_load;
    logic               w_set_inc;
    logic               w_loop_load;
    logic               w_loop_inc;
    logic               w_accept;
    logic               w_sample;
    logic               w_mis;
    logic [3:0]         w_fail_nxt;

    assign w_accept    = (r_state == ST_IDLE) && start;
    assign w_sample    = (r_state == ST_SAMPLE);
    assign w_set_load  = (r_state == ST_IDLE) || w_sample;
    assign w_set_inc   = (r_state == ST_SETTLE);
    assign w_loop_load = (r_state == ST_IDLE);
    assign w_loop_inc  = w_sample && (r_v == 2'd3);

    assign w_mis      = (q != exp_q(r_v));
    assign w_fail_nxt = r_fail | (w_mis ? (4'b0001 << r_v) : 4'b0000);

    and2_tester_cnt #(
        .W    (4),
        .TERM (4'(SETTLE - 1))
    ) u_settle_cnt (
        .i_ck       (ck),
        .i_nrst     (nrst),
        .i_load     (w_set_load),
        .i_load_val (4'd0),
        .i_inc      (w_set_inc),
        .o_tc       (w_set_tc)
    );

    and2_tester_cnt #(
        .W    (8),
        .TERM (8'(LOOPS - 1))
    ) u_loop_cnt (
        .i_ck       (ck),
        .i_nrst     (nrst),
        .i_load     (w_loop_load),
        .i_load_val (8'd0),
        .i_inc      (w_loop_inc),
        .o_tc       (w_loop_tc)
    );

    always_ff @(posedge ck or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
            r_v     <= '0;
            r_fail  <= '0;
            r_pass  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_i0    <= 1'b0;
            r_i1    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_SETTLE;
                        r_v     <= '0;
                        r_fail  <= '0;
                        r_busy  <= 1'b1;
                        r_i0    <= 1'b0;
                        r_i1    <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (w_set_tc) begin
                        r_state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    r_fail <= w_fail_nxt;
                    r_v    <= r_v + 2'd1;
                    // pass is registered here so it already covers the last sample
                    if ((r_v == 2'd3) && w_loop_tc) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_fail_nxt == 4'b0000);
                        r_i0    <= 1'b0;
                        r_i1    <= 1'b0;
                    end else begin
                        r_state      <= ST_SETTLE;
                        {r_i1, r_i0} <= r_v + 2'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef AND2_TESTER_ERRCNT_EN
    logic [7:0] r_err;

    always_ff @(posedge ck or negedge nrst) begin
        if (!nrst) begin
            r_err <= '0;
        end else if (w_accept) begin
            r_err <= '0;
        end else if (w_sample && w_mis && (r_err != 8'hFF)) begin
            r_err <= r_err + 8'd1;
        end
    end

    assign err_cnt = r_err;
`else
    logic w_unused;
    assign w_unused = w_accept;
`endif

    assign i0       = r_i0;
    assign i1       = r_i1;
    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_pass;
    assign fail_vec = r_fail;

endmodule

// File: tb/tb_and2_tester.sv
// Directed-vector bench for and2_tester with behavioural cell models.
// Three instances cover SETTLE/LOOPS variants; err_cnt checked when enabled.
module tb_and2_tester;

    logic ck = 1'b0;
    logic nrst = 1'b0;

    logic       st   [3];
    logic       q    [3];
    logic       i0   [3];
    logic       i1   [3];
    logic       busy [3];
    logic       done [3];
    logic       pass [3];
    logic [3:0] fv   [3];
`ifdef AND2_TESTER_ERRCNT_EN
    logic [7:0] ec   [3];
`endif
    int mode [3];

    int n_tot = 0;
    int n_pass = 0;

    always #5 ck = ~ck;

    // cell models: 0 AND, 1 stuck-0, 2 stuck-1, 3 OR, 4 XOR
    always_comb begin
        for (int d = 0; d < 3; d++) begin
            q[d] = 1'b0;
            case (mode[d])
                0: q[d] = i0[d] & i1[d];
                1: q[d] = 1'b0;
                2: q[d] = 1'b1;
                3: q[d] = i0[d] | i1[d];
                4: q[d] = i0[d] ^ i1[d];
                default: q[d] = 1'b0;
            endcase
        end
    end

    and2_tester #(.SETTLE(2), .LOOPS(1)) u_a (
        .ck(ck), .nrst(nrst), .start(st[0]), .q(q[0]),
        .i0(i0[0]), .i1(i1[0]), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .fail_vec(fv[0])
`ifdef AND2_TESTER_ERRCNT_EN
        , .err_cnt(ec[0])
`endif
    );

    and2_tester #(.SETTLE(2), .LOOPS(3)) u_b (
        .ck(ck), .nrst(nrst), .start(st[1]), .q(q[1]),
        .i0(i0[1]), .i1(i1[1]), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .fail_vec(fv[1])
`ifdef AND2_TESTER_ERRCNT_EN
        , .err_cnt(ec[1])
`endif
    );

    and2_tester #(.SETTLE(1), .LOOPS(1)) u_c (
        .ck(ck), .nrst(nrst), .start(st[2]), .q(q[2]),
        .i0(i0[2]), .i1(i1[2]), .busy(busy[2]), .done(done[2]),
        .pass(pass[2]), .fail_vec(fv[2])
`ifdef AND2_TESTER_ERRCNT_EN
        , .err_cnt(ec[2])
`endif
    );

    typedef struct {
        int         m;
        logic       ep;
        logic [3:0] efv;
        int         eerr;
        int         poke;
    } tv_t;

    tv_t tv [6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    function automatic logic [31:0] rst_vec(input int d);
        return 32'({busy[d], done[d], pass[d], fv[d], i1[d], i0[d]});
    endfunction

    task automatic do_run(input int d, input int m, input int settle,
                          input int lat, input logic ep,
                          input logic [3:0] efv, input int eerr,
                          input int poke, input string tag);
        int k;
        bit seq_ok;
        mode[d] = m;
        st[d] = 1'b1;
        @(posedge ck); #1;
        st[d] = 1'b0;
        chk({tag, ".busy1"}, 32'(busy[d]), 32'd1);
        k = 1;
        seq_ok = 1'b1;
        while (done[d] !== 1'b1 && k < 400) begin
            if ({i1[d], i0[d]} !== 2'(((k - 1) / (settle + 1)) % 4))
                seq_ok = 1'b0;
            st[d] = (k == poke);
            @(posedge ck); #1;
            k++;
        end
        st[d] = 1'b0;
        chk({tag, ".lat"}, 32'(k), 32'(lat));
        chk({tag, ".ivec"}, 32'(seq_ok), 32'd1);
        chk({tag, ".pass"}, 32'(pass[d]), 32'(ep));
        chk({tag, ".fv"}, 32'(fv[d]), 32'(efv));
        chk({tag, ".busy0"}, 32'(busy[d]), 32'd0);
`ifdef AND2_TESTER_ERRCNT_EN
        chk({tag, ".err"}, 32'(ec[d]), 32'(eerr));
`else
        if (eerr < 0) $display("note: negative error count %0d", eerr);
`endif
        @(posedge ck); #1;
        chk({tag, ".done0"}, 32'(done[d]), 32'd0);
        chk({tag, ".idle"}, 32'({busy[d], i1[d], i0[d]}), 32'd0);
        chk({tag, ".hold"}, 32'({pass[d], fv[d]}), 32'({ep, efv}));
    endtask

    initial begin
        int k;
        bit seen;
        for (int d = 0; d < 3; d++) begin
            st[d] = 1'b0;
            mode[d] = 0;
        end
        tv[0] = '{0, 1'b1, 4'b0000, 0, 0};
        tv[1] = '{1, 1'b0, 4'b1000, 1, 0};
        tv[2] = '{2, 1'b0, 4'b0111, 3, 0};
        tv[3] = '{3, 1'b0, 4'b0110, 2, 4};
        tv[4] = '{4, 1'b0, 4'b1110, 3, 7};
        tv[5] = '{0, 1'b1, 4'b0000, 0, 11};

        #2;
        for (int d = 0; d < 3; d++) chk($sformatf("rst%0d", d), rst_vec(d), 32'd0);
        @(posedge ck); #1;
        nrst = 1'b1;
        @(posedge ck); #1;

        for (int t = 0; t < 6; t++)
            do_run(0, tv[t].m, 2, 13, tv[t].ep, tv[t].efv, tv[t].eerr,
                   tv[t].poke, $sformatf("tv%0d", t));

        do_run(1, 2, 2, 37, 1'b0, 4'b0111, 9, 0, "loop3");

        // start held high: back-to-back runs on the SETTLE=1 instance
        mode[2] = 0;
        st[2] = 1'b1;
        k = 0;
        do begin
            @(posedge ck); #1;
            k++;
        end while (done[2] !== 1'b1 && k < 100);
        chk("held.first", 32'(k), 32'd9);
        for (int r = 0; r < 2; r++) begin
            k = 0;
            do begin
                @(posedge ck); #1;
                k++;
            end while (done[2] !== 1'b1 && k < 100);
            chk($sformatf("held.period%0d", r), 32'(k), 32'd10);
        end
        st[2] = 1'b0;
        repeat (2) begin
            @(posedge ck); #1;
        end
        chk("held.stop", 32'({busy[2], pass[2]}), 32'b01);

        // reset in the middle of a run
        mode[0] = 0;
        st[0] = 1'b1;
        @(posedge ck); #1;
        st[0] = 1'b0;
        repeat (4) begin
            @(posedge ck); #1;
        end
        chk("mid.vec", 32'({i1[0], i0[0]}), 32'b01);
        #2;
        nrst = 1'b0;
        #1;
        chk("mid.rst", rst_vec(0), 32'd0);
        repeat (2) @(posedge ck);
        #1;
        nrst = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(posedge ck); #1;
            if (done[0] !== 1'b0 || busy[0] !== 1'b0) seen = 1'b1;
        end
        chk("mid.quiet", 32'(seen), 32'd0);
        do_run(0, 0, 2, 13, 1'b1, 4'b0000, 0, 0, "post");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
